id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS pipeline, directly upstream of the EX-stage ALU.
//  Latches decoded operands and control from ID, detects load-use hazards (stall + bubble), applies
//  branch/jump flush, and resolves EX/MEM and MEM/WB forwarding to drive the ALU A/B/ALUFun/Sign.
// PARAMETERS
//  DW      32  datapath width (ALU operands, PC+4, forwarded results)
//  RW      5   register address width
// PORTS
//  clk            in   1   pipeline clock, all state on rising edge
//  reset          in   1   asynchronous, active-high; clears every register
//  id_valid       in   1   ID holds a real instruction
//  id_pc4         in   DW  PC+4 of ID instruction
//  id_rs_addr     in   RW  rs field;  id_rt_addr in RW rt field
//  id_dst         in   RW  final write-back register (0 = no write)
//  id_rs_data     in   DW  regfile rs read;  id_rt_data in DW regfile rt read
//  id_imm         in   DW  already sign/zero/lui-extended immediate
//  id_shamt       in   5   shift amount
//  id_alufun      in   6   ALUFun code;  id_sign in 1 signed compare/overflow select
//  id_alusrc1     in   1   1: A = zero-extended shamt;  id_alusrc2 in 1  1: B = imm
//  id_ctrl        in   4   {reg_write, mem_read, mem_write, mem_to_reg}
//  flush          in   1   branch/jump taken: kill ID instruction this edge
//  exm_reg_write  in   1   / exm_dst in RW / exm_result in DW : EX/MEM forwarding source
//  mwb_reg_write  in   1   / mwb_dst in RW / mwb_result in DW : MEM/WB forwarding source
//  stall_id       out  1   combinational: freeze PC and IF/ID this cycle
//  ex_valid       out  1   / ex_pc4 out DW / ex_dst out RW / ex_ctrl out 4 : registered
//  ex_alu_a       out  DW  ALU A;  ex_alu_b out DW ALU B (combinational from regs + forwards)
//  ex_alufun      out  6   / ex_sign out 1 : registered ALU control
//  ex_store_data  out  DW  forwarded rt value for sw
// BEHAVIOUR
//  - Reset: every register 0 -> ex_valid=0, ex_ctrl=0, ex_dst=0, ex_alufun=0, ex_pc4=0, operands 0.
//  - Edge priority: reset > flush > load-use bubble > normal load. Latency ID->EX = 1 cycle.
//  - hazard = ex_valid & ex_ctrl.mem_read & ex_dst!=0 & id_valid &
//    (ex_dst==id_rs_addr | ex_dst==id_rt_addr). stall_id = hazard & ~flush.
//  - Bubble (flush or hazard): ex_valid=0, ex_ctrl=0, ex_dst=0, ex_alufun=0; data regs don't-care
//    but loaded 0. Hazard lasts exactly one cycle (load moves to MEM, then forwarded from MEM/WB).
//  - Forward rs (same for rt), on registered addresses: if exm_reg_write & exm_dst!=0 &
//    exm_dst==ex_rs -> exm_result; elif mwb_reg_write & mwb_dst!=0 & mwb_dst==ex_rs -> mwb_result;
//    else latched regfile data. EX/MEM always beats MEM/WB. $0 never forwarded.
//  - ex_alu_a = alusrc1 ? {27'b0, shamt} : fwd_rs;  ex_alu_b = alusrc2 ? imm : fwd_rt;
//    ex_store_data = fwd_rt regardless of alusrc2.
//  - Same-cycle WB write vs ID read is resolved by the register file, not here.
//  - Reset mid-stream: in-flight EX instruction is discarded; no partial state survives.
// STRUCTURE
//  - Package mips_pipe_pkg: CTRL_* bit indices, ALUFun constants (ADD=6'b000000), FWD_SEL enum
//    {FWD_REG, FWD_EXM, FWD_MWB}, BUBBLE control constant.
//  - One sub-module: ex_forward_unit (pure combinational rs/rt select); hazard logic and
//    registers stay in this module.
// TESTING
//  1 reset held 3 cycles mid-traffic -> all ex_* = 0, stall_id=0; first instr after release in EX next edge.
//  2 add $3,$1,$2 then sub $4,$3,$1 with exm_result=32'h0000_0005 -> ex_alu_a=5, no stall.
//  3 exm and mwb both write $3 (7 vs 9) -> ex_alu_b=7; dst=$0 with result 9 -> regfile data used.
//  4 lw $5 then add $6,$5,$5 -> stall_id=1 one cycle, ex_valid=0/ex_ctrl=0 bubble, then A=B=mwb_result.
//  5 load-use hazard and flush same cycle -> stall_id=0, bubble inserted, no instruction lost.
//  6 sll $2,$1,4 (alusrc1=1) and addi imm=32'hFFFF_FFFC -> ex_alu_a=4; ex_alu_b=32'hFFFF_FFFC.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the ID/EX stage: control bit layout, ALU codes and
// forwarding select encoding.
package mips_pipe_pkg;

    localparam int unsigned CTRL_W          = 4;
    localparam int unsigned CTRL_REG_WRITE  = 3;
    localparam int unsigned CTRL_MEM_READ   = 2;
    localparam int unsigned CTRL_MEM_WRITE  = 1;
    localparam int unsigned CTRL_MEM_TO_REG = 0;

    localparam logic [CTRL_W-1:0] BUBBLE = '0;

    localparam logic [5:0] ALUFUN_ADD = 6'b000000;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_EXM,
        FWD_MWB
    } fwd_sel_e;

endpackage

// File: rtl/ex_forward_unit.sv
// Operand forwarding for the EX stage: picks the youngest in-flight result for rs and rt,
// falling back to the value read from the register file in ID.
module ex_forward_unit
    import mips_pipe_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic [RW-1:0] rs_addr_i,
    input  logic [RW-1:0] rt_addr_i,
    input  logic [DW-1:0] rs_data_i,
    input  logic [DW-1:0] rt_data_i,
    input  logic          exm_reg_write_i,
    input  logic [RW-1:0] exm_dst_i,
    input  logic [DW-1:0] exm_result_i,
    input  logic          mwb_reg_write_i,
    input  logic [RW-1:0] mwb_dst_i,
    input  logic [DW-1:0] mwb_result_i,
    output logic [DW-1:0] rs_fwd_o,
    output logic [DW-1:0] rt_fwd_o
);

    fwd_sel_e rs_sel;
    fwd_sel_e rt_sel;

    logic exm_hit_rs, exm_hit_rt, mwb_hit_rs, mwb_hit_rt;

    // $0 is hardwired zero, so a write to it is never a forwarding source.
    assign exm_hit_rs = exm_reg_write_i && (exm_dst_i != '0) && (exm_dst_i == rs_addr_i);
    assign exm_hit_rt = exm_reg_write_i && (exm_dst_i != '0) && (exm_dst_i == rt_addr_i);
    assign mwb_hit_rs = mwb_reg_write_i && (mwb_dst_i != '0) && (mwb_dst_i == rs_addr_i);
    assign mwb_hit_rt = mwb_reg_write_i && (mwb_dst_i != '0) && (mwb_dst_i == rt_addr_i);

    always_comb begin
        rs_sel = FWD_REG;
        rt_sel = FWD_REG;
        if (exm_hit_rs) begin
            rs_sel = FWD_EXM;
        end else if (mwb_hit_rs) begin
            rs_sel = FWD_MWB;
        end
        if (exm_hit_rt) begin
            rt_sel = FWD_EXM;
        end else if (mwb_hit_rt) begin
            rt_sel = FWD_MWB;
        end
    end

    always_comb begin
        case (rs_sel)
            FWD_EXM: rs_fwd_o = exm_result_i;
            FWD_MWB: rs_fwd_o = mwb_result_i;
            default: rs_fwd_o = rs_data_i;
        endcase
        case (rt_sel)
            FWD_EXM: rt_fwd_o = exm_result_i;
            FWD_MWB: rt_fwd_o = mwb_result_i;
            default: rt_fwd_o = rt_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: latches decoded operands/control, inserts load-use bubbles,
// honours branch flush and drives forwarded ALU operands for EX.
module id_ex_operand_stage
    import mips_pipe_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          id_valid_i,
    input  logic [DW-1:0] id_pc4_i,
    input  logic [RW-1:0] id_rs_addr_i,
    input  logic [RW-1:0] id_rt_addr_i,
    input  logic [RW-1:0] id_dst_i,
    input  logic [DW-1:0] id_rs_data_i,
    input  logic [DW-1:0] id_rt_data_i,
    input  logic [DW-1:0] id_imm_i,
    input  logic [4:0]    id_shamt_i,
    input  logic [5:0]    id_alufun_i,
    input  logic          id_sign_i,
    input  logic          id_alusrc1_i,
    input  logic          id_alusrc2_i,
    input  logic [3:0]    id_ctrl_i,
    input  logic          flush_i,
    input  logic          exm_reg_write_i,
    input  logic [RW-1:0] exm_dst_i,
    input  logic [DW-1:0] exm_result_i,
    input  logic          mwb_reg_write_i,
    input  logic [RW-1:0] mwb_dst_i,
    input  logic [DW-1:0] mwb_result_i,
    output logic          stall_id_o,
    output logic          ex_valid_o,
    output logic [DW-1:0] ex_pc4_o,
    output logic [RW-1:0] ex_dst_o,
    output logic [3:0]    ex_ctrl_o,
    output logic [DW-1:0] ex_alu_a_o,
    output logic [DW-1:0] ex_alu_b_o,
    output logic [5:0]    ex_alufun_o,
    output logic          ex_sign_o,
    output logic [DW-1:0] ex_store_data_o
);

    logic          valid_q,   valid_d;
    logic [DW-1:0] pc4_q,     pc4_d;
    logic [RW-1:0] dst_q,     dst_d;
    logic [3:0]    ctrl_q,    ctrl_d;
    logic [5:0]    alufun_q,  alufun_d;
    logic          sign_q,    sign_d;
    logic [RW-1:0] rs_addr_q, rs_addr_d;
    logic [RW-1:0] rt_addr_q, rt_addr_d;
    logic [DW-1:0] rs_data_q, rs_data_d;
    logic [DW-1:0] rt_data_q, rt_data_d;
    logic [DW-1:0] imm_q,     imm_d;
    logic [4:0]    shamt_q,   shamt_d;
    logic          src1_q,    src1_d;
    logic          src2_q,    src2_d;

    logic          hazard;
    logic          bubble;
    logic [DW-1:0] rs_fwd, rt_fwd;

    // The load in EX can only be forwarded once it reaches MEM/WB, so hold ID one cycle.
    assign hazard = valid_q && ctrl_q[CTRL_MEM_READ] && (dst_q != '0) && id_valid_i &&
                    ((dst_q == id_rs_addr_i) || (dst_q == id_rt_addr_i));
    assign stall_id_o = hazard && !flush_i;
    assign bubble     = flush_i || hazard;

    always_comb begin
        valid_d   = 1'b0;
        pc4_d     = '0;
        dst_d     = '0;
        ctrl_d    = BUBBLE;
        alufun_d  = ALUFUN_ADD;
        sign_d    = 1'b0;
        rs_addr_d = '0;
        rt_addr_d = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        shamt_d   = '0;
        src1_d    = 1'b0;
        src2_d    = 1'b0;
        if (!bubble) begin
            valid_d   = id_valid_i;
            pc4_d     = id_pc4_i;
            dst_d     = id_valid_i ? id_dst_i : '0;
            ctrl_d    = id_valid_i ? id_ctrl_i : BUBBLE;
            alufun_d  = id_alufun_i;
            sign_d    = id_sign_i;
            rs_addr_d = id_rs_addr_i;
            rt_addr_d = id_rt_addr_i;
            rs_data_d = id_rs_data_i;
            rt_data_d = id_rt_data_i;
            imm_d     = id_imm_i;
            shamt_d   = id_shamt_i;
            src1_d    = id_alusrc1_i;
            src2_d    = id_alusrc2_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q   <= 1'b0;
            pc4_q     <= '0;
            dst_q     <= '0;
            ctrl_q    <= BUBBLE;
            alufun_q  <= ALUFUN_ADD;
            sign_q    <= 1'b0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            shamt_q   <= '0;
            src1_q    <= 1'b0;
            src2_q    <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc4_q     <= pc4_d;
            dst_q     <= dst_d;
            ctrl_q    <= ctrl_d;
            alufun_q  <= alufun_d;
            sign_q    <= sign_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            shamt_q   <= shamt_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
        end
    end

    ex_forward_unit #(
        .DW(DW),
        .RW(RW)
    ) u_fwd (
        .rs_addr_i       (rs_addr_q),
        .rt_addr_i       (rt_addr_q),
        .rs_data_i       (rs_data_q),
        .rt_data_i       (rt_data_q),
        .exm_reg_write_i (exm_reg_write_i),
        .exm_dst_i       (exm_dst_i),
        .exm_result_i    (exm_result_i),
        .mwb_reg_write_i (mwb_reg_write_i),
        .mwb_dst_i       (mwb_dst_i),
        .mwb_result_i    (mwb_result_i),
        .rs_fwd_o        (rs_fwd),
        .rt_fwd_o        (rt_fwd)
    );

    assign ex_valid_o      = valid_q;
    assign ex_pc4_o        = pc4_q;
    assign ex_dst_o        = dst_q;
    assign ex_ctrl_o       = ctrl_q;
    assign ex_alufun_o     = alufun_q;
    assign ex_sign_o       = sign_q;
    assign ex_alu_a_o      = src1_q ? {{(DW-5){1'b0}}, shamt_q} : rs_fwd;
    assign ex_alu_b_o      = src2_q ? imm_q : rt_fwd;
    assign ex_store_data_o = rt_fwd;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed scoreboard bench for the ID/EX operand stage: hazards, flush, forwarding, reset.
module tb_id_ex_operand_stage;

    typedef struct {
        logic        valid;
        logic [31:0] pc4;
        logic [4:0]  rs, rt, dst;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  shamt;
        logic [5:0]  alufun;
        logic        sign, src1, src2;
        logic [3:0]  ctrl;
    } id_t;

    typedef struct {
        logic        ew;
        logic [4:0]  ed;
        logic [31:0] er;
        logic        mw;
        logic [4:0]  md;
        logic [31:0] mr;
    } fw_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc4;
        logic [4:0]  dst;
        logic [3:0]  ctrl;
        logic [5:0]  alufun;
        logic        sign;
        logic [31:0] a, b, st;
    } exp_t;

    localparam logic [3:0] C_R  = 4'b1000;
    localparam logic [3:0] C_LW = 4'b1101;
    localparam logic [5:0] F_ADD = 6'b000000;
    localparam logic [5:0] F_SUB = 6'b000001;
    localparam logic [5:0] F_OR  = 6'b011110;
    localparam logic [5:0] F_SLL = 6'b100000;

    logic        clk, reset;
    logic        id_valid, id_sign, id_alusrc1, id_alusrc2, flush;
    logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs_addr, id_rt_addr, id_dst, id_shamt;
    logic [5:0]  id_alufun;
    logic [3:0]  id_ctrl;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_dst, mwb_dst;
    logic [31:0] exm_result, mwb_result;
    logic        stall_id, ex_valid, ex_sign;
    logic [31:0] ex_pc4, ex_alu_a, ex_alu_b, ex_store_data;
    logic [4:0]  ex_dst;
    logic [3:0]  ex_ctrl;
    logic [5:0]  ex_alufun;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    id_ex_operand_stage dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .id_valid_i      (id_valid),
        .id_pc4_i        (id_pc4),
        .id_rs_addr_i    (id_rs_addr),
        .id_rt_addr_i    (id_rt_addr),
        .id_dst_i        (id_dst),
        .id_rs_data_i    (id_rs_data),
        .id_rt_data_i    (id_rt_data),
        .id_imm_i        (id_imm),
        .id_shamt_i      (id_shamt),
        .id_alufun_i     (id_alufun),
        .id_sign_i       (id_sign),
        .id_alusrc1_i    (id_alusrc1),
        .id_alusrc2_i    (id_alusrc2),
        .id_ctrl_i       (id_ctrl),
        .flush_i         (flush),
        .exm_reg_write_i (exm_reg_write),
        .exm_dst_i       (exm_dst),
        .exm_result_i    (exm_result),
        .mwb_reg_write_i (mwb_reg_write),
        .mwb_dst_i       (mwb_dst),
        .mwb_result_i    (mwb_result),
        .stall_id_o      (stall_id),
        .ex_valid_o      (ex_valid),
        .ex_pc4_o        (ex_pc4),
        .ex_dst_o        (ex_dst),
        .ex_ctrl_o       (ex_ctrl),
        .ex_alu_a_o      (ex_alu_a),
        .ex_alu_b_o      (ex_alu_b),
        .ex_alufun_o     (ex_alufun),
        .ex_sign_o       (ex_sign),
        .ex_store_data_o (ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic id_t mk(input logic [31:0] pc4, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] dst, input logic [31:0] rsd,
                               input logic [31:0] rtd, input logic [31:0] imm,
                               input logic [4:0] sh, input logic [5:0] fn, input logic sg,
                               input logic s1, input logic s2, input logic [3:0] ctrl);
        id_t r;
        r.valid = 1'b1; r.pc4 = pc4; r.rs = rs; r.rt = rt; r.dst = dst;
        r.rsd = rsd; r.rtd = rtd; r.imm = imm; r.shamt = sh; r.alufun = fn;
        r.sign = sg; r.src1 = s1; r.src2 = s2; r.ctrl = ctrl;
        return r;
    endfunction

    function automatic fw_t fw(input logic ew, input logic [4:0] ed, input logic [31:0] er,
                               input logic mw, input logic [4:0] md, input logic [31:0] mr);
        fw_t r;
        r.ew = ew; r.ed = ed; r.er = er; r.mw = mw; r.md = md; r.mr = mr;
        return r;
    endfunction

    function automatic exp_t ex(input id_t i, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] st);
        exp_t r;
        r.valid = i.valid; r.pc4 = i.pc4; r.dst = i.dst; r.ctrl = i.ctrl;
        r.alufun = i.alufun; r.sign = i.sign; r.a = a; r.b = b; r.st = st;
        return r;
    endfunction

    function automatic exp_t bub();
        exp_t r;
        r.valid = 1'b0; r.pc4 = '0; r.dst = '0; r.ctrl = '0;
        r.alufun = '0; r.sign = 1'b0; r.a = '0; r.b = '0; r.st = '0;
        return r;
    endfunction

    // One pipeline cycle: drive ID at negedge, check stall, then check EX after the edge
    // with forwarding sources that belong to the instruction now in EX.
    task automatic cycle(input string tag, input id_t i, input logic fl, input logic rst,
                         input fw_t f, input exp_t e, input logic exp_stall);
        exp_t got;
        @(negedge clk);
        reset = rst; flush = fl;
        id_valid = i.valid; id_pc4 = i.pc4; id_rs_addr = i.rs; id_rt_addr = i.rt;
        id_dst = i.dst; id_rs_data = i.rsd; id_rt_data = i.rtd; id_imm = i.imm;
        id_shamt = i.shamt; id_alufun = i.alufun; id_sign = i.sign;
        id_alusrc1 = i.src1; id_alusrc2 = i.src2; id_ctrl = i.ctrl;
        #1;
        check_val({tag, ".stall"}, 32'(stall_id), 32'(exp_stall));
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        exm_reg_write = f.ew; exm_dst = f.ed; exm_result = f.er;
        mwb_reg_write = f.mw; mwb_dst = f.md; mwb_result = f.mr;
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, ".queue_empty"}, 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check_val({tag, ".valid"},  32'(ex_valid),  32'(got.valid));
            check_val({tag, ".pc4"},    ex_pc4,         got.pc4);
            check_val({tag, ".dst"},    32'(ex_dst),    32'(got.dst));
            check_val({tag, ".ctrl"},   32'(ex_ctrl),   32'(got.ctrl));
            check_val({tag, ".alufun"}, 32'(ex_alufun), 32'(got.alufun));
            check_val({tag, ".sign"},   32'(ex_sign),   32'(got.sign));
            check_val({tag, ".alu_a"},  ex_alu_a,       got.a);
            check_val({tag, ".alu_b"},  ex_alu_b,       got.b);
            check_val({tag, ".store"},  ex_store_data,  got.st);
        end
    endtask

    initial begin
        id_t i_add, i_sub, i_or, i_z, i_lw, i_use, i_lw2, i_use2, i_tgt, i_rt, i_sll, i_addi;
        id_t nop;
        fw_t fn;

        nop = mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        nop.valid = 1'b0;
        fn = fw(1'b0, '0, '0, 1'b0, '0, '0);

        reset = 1'b1; flush = 1'b0;
        id_valid = 1'b0; id_pc4 = '0; id_rs_addr = '0; id_rt_addr = '0; id_dst = '0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_shamt = '0; id_alufun = '0;
        id_sign = 1'b0; id_alusrc1 = 1'b0; id_alusrc2 = 1'b0; id_ctrl = '0;
        exm_reg_write = 1'b0; exm_dst = '0; exm_result = '0;
        mwb_reg_write = 1'b0; mwb_dst = '0; mwb_result = '0;

        i_add  = mk(32'h8,  5'd1, 5'd2, 5'd3, 32'd10, 32'd20, '0, '0, F_ADD, 1'b1, 1'b0, 1'b0, C_R);
        i_sub  = mk(32'hC,  5'd3, 5'd1, 5'd4, 32'hDEAD, 32'd10, '0, '0, F_SUB, 1'b1, 1'b0, 1'b0,
                    C_R);
        i_or   = mk(32'h10, 5'd1, 5'd3, 5'd7, 32'h11, 32'h33, '0, '0, F_OR, 1'b0, 1'b0, 1'b0, C_R);
        i_z    = mk(32'h14, 5'd0, 5'd0, 5'd8, 32'h22, 32'h44, '0, '0, F_ADD, 1'b1, 1'b0, 1'b0, C_R);
        i_lw   = mk(32'h18, 5'd1, 5'd5, 5'd5, 32'h100, 32'h0, 32'h0, '0, F_ADD, 1'b1, 1'b0, 1'b1,
                    C_LW);
        i_use  = mk(32'h1C, 5'd5, 5'd5, 5'd6, 32'hBAD, 32'hBAD, '0, '0, F_ADD, 1'b1, 1'b0, 1'b0,
                    C_R);
        i_lw2  = mk(32'h20, 5'd2, 5'd5, 5'd5, 32'h200, 32'h0, 32'h4, '0, F_ADD, 1'b1, 1'b0, 1'b1,
                    C_LW);
        i_use2 = mk(32'h24, 5'd5, 5'd1, 5'd6, 32'hBAD, 32'h1, '0, '0, F_ADD, 1'b1, 1'b0, 1'b0, C_R);
        i_tgt  = mk(32'h40, 5'd1, 5'd2, 5'd9, 32'h1, 32'h2, '0, '0, F_SUB, 1'b1, 1'b0, 1'b0, C_R);
        i_rt   = mk(32'h44, 5'd1, 5'd5, 5'd7, 32'h3, 32'hBAD, '0, '0, F_OR, 1'b0, 1'b0, 1'b0, C_R);
        i_sll  = mk(32'h48, 5'd0, 5'd1, 5'd2, 32'h0, 32'h8, '0, 5'd4, F_SLL, 1'b0, 1'b1, 1'b0, C_R);
        i_addi = mk(32'h4C, 5'd1, 5'd2, 5'd3, 32'h3, 32'h55, 32'hFFFF_FFFC, '0, F_ADD, 1'b1, 1'b0,
                    1'b1, C_R);

        // Power-on reset while ID already presents traffic.
        cycle("rst0", i_add, 1'b0, 1'b1, fn, bub(), 1'b0);
        cycle("rst1", i_add, 1'b0, 1'b1, fn, bub(), 1'b0);

        // EX/MEM forwarding of rs.
        cycle("add", i_add, 1'b0, 1'b0, fn, ex(i_add, 32'd10, 32'd20, 32'd20), 1'b0);
        cycle("sub", i_sub, 1'b0, 1'b0, fw(1'b1, 5'd3, 32'h5, 1'b0, '0, '0),
              ex(i_sub, 32'h5, 32'd10, 32'd10), 1'b0);

        // EX/MEM beats MEM/WB; $0 never forwarded.
        cycle("prio", i_or, 1'b0, 1'b0, fw(1'b1, 5'd3, 32'h7, 1'b1, 5'd3, 32'h9),
              ex(i_or, 32'h11, 32'h7, 32'h7), 1'b0);
        cycle("zero", i_z, 1'b0, 1'b0, fw(1'b1, 5'd0, 32'h9, 1'b1, 5'd0, 32'h9),
              ex(i_z, 32'h22, 32'h44, 32'h44), 1'b0);
        cycle("mwb_only", i_z, 1'b0, 1'b0, fw(1'b0, 5'd0, 32'h9, 1'b1, 5'd0, 32'h9),
              ex(i_z, 32'h22, 32'h44, 32'h44), 1'b0);

        // Reset held three cycles mid-traffic, then the next instruction lands in EX.
        cycle("rst_mid0", i_lw, 1'b0, 1'b1, fn, bub(), 1'b0);
        cycle("rst_mid1", i_lw, 1'b0, 1'b1, fn, bub(), 1'b0);
        cycle("rst_mid2", i_lw, 1'b0, 1'b1, fn, bub(), 1'b0);
        cycle("post_rst", i_lw, 1'b0, 1'b0, fn, ex(i_lw, 32'h100, 32'h0, 32'h0), 1'b0);

        // Load-use on rs/rt: one stall cycle with a bubble, then MEM/WB forwarding.
        cycle("lu_stall", i_use, 1'b0, 1'b0, fn, bub(), 1'b1);
        cycle("lu_fwd", i_use, 1'b0, 1'b0, fw(1'b0, '0, '0, 1'b1, 5'd5, 32'h77),
              ex(i_use, 32'h77, 32'h77, 32'h77), 1'b0);

        // Load-use coinciding with flush: no stall, bubble, branch target follows.
        cycle("lw2", i_lw2, 1'b0, 1'b0, fn, ex(i_lw2, 32'h200, 32'h4, 32'h0), 1'b0);
        cycle("lu_flush", i_use2, 1'b1, 1'b0, fn, bub(), 1'b0);
        cycle("tgt", i_tgt, 1'b0, 1'b0, fn, ex(i_tgt, 32'h1, 32'h2, 32'h2), 1'b0);

        // Load-use through rt only.
        cycle("lw3", i_lw2, 1'b0, 1'b0, fn, ex(i_lw2, 32'h200, 32'h4, 32'h0), 1'b0);
        cycle("rt_stall", i_rt, 1'b0, 1'b0, fn, bub(), 1'b1);
        cycle("rt_fwd", i_rt, 1'b0, 1'b0, fw(1'b0, '0, '0, 1'b1, 5'd5, 32'h99),
              ex(i_rt, 32'h3, 32'h99, 32'h99), 1'b0);

        // Shamt and immediate operand selection.
        cycle("sll", i_sll, 1'b0, 1'b0, fn, ex(i_sll, 32'h4, 32'h8, 32'h8), 1'b0);
        cycle("addi", i_addi, 1'b0, 1'b0, fn, ex(i_addi, 32'h3, 32'hFFFF_FFFC, 32'h55), 1'b0);
        cycle("nop", nop, 1'b0, 1'b0, fn, ex(nop, 32'h0, 32'h0, 32'h0), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
